// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: ALU operation encoding, major opcodes and funct7
// values. Used by the decode stage and by the ALU.
package riscv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Map funct3 (plus the SUB/SRA alternate-encoding flag) to an ALU operation.
  function automatic alu_op_e f3_to_alu(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/regfile.sv
// Architectural register file: two combinational read ports, one synchronous
// write port. x0 is hardwired to zero.
module regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            we,
  input  logic [4:0]      wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  logic [XLEN-1:0] regs_q [NREGS];

  // Register storage: cleared on reset, written on wb strobe except x0.
  // NOTE: this array is reset explicitly because every register must read 0
  // after reset; that makes it flops rather than an inferable RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we && wr_addr != 5'd0 && int'(wr_addr) < NREGS) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Read ports: x0 and out-of-range indices return zero.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_addr != 5'd0 && int'(rs1_addr) < NREGS) rs1_data = regs_q[rs1_addr];
    if (rs2_addr != 5'd0 && int'(rs2_addr) < NREGS) rs2_data = regs_q[rs2_addr];
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes OP / OP-IMM / LUI, reads operands with
// writeback bypass, and holds the result in a single valid/ready output
// register.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_val,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rs1_val,
  output logic [XLEN-1:0] rs2_val,
  output logic [3:0]      alu_op,
  output logic [4:0]      rd,
  output logic            rd_we,
  output logic            illegal
);

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rs1_idx, rs2_idx, rd_idx;

  assign opcode  = instr[6:0];
  assign rd_idx  = instr[11:7];
  assign funct3  = instr[14:12];
  assign rs1_idx = instr[19:15];
  assign rs2_idx = instr[24:20];
  assign funct7  = instr[31:25];

  logic [XLEN-1:0] rf_rs1, rf_rs2, byp_rs1, byp_rs2;

  regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (rs1_idx),
    .rs2_addr (rs2_idx),
    .rs1_data (rf_rs1),
    .rs2_data (rf_rs2),
    .we       (wb_en),
    .wr_addr  (wb_rd),
    .wr_data  (wb_val)
  );

  // Operand bypass: a writeback in the same cycle wins over the stored value.
  always_comb begin
    byp_rs1 = rf_rs1;
    byp_rs2 = rf_rs2;
    if (wb_en && wb_rd == rs1_idx && rs1_idx != 5'd0) byp_rs1 = wb_val;
    if (wb_en && wb_rd == rs2_idx && rs2_idx != 5'd0) byp_rs2 = wb_val;
  end

  logic [XLEN-1:0] dec_rs1, dec_rs2;
  alu_op_e         dec_op;
  logic            dec_illegal;

  // Instruction decode; illegal encodings fall through to ADD with zero operands.
  // NOTE: every output gets a default first so no path leaves a value unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    dec_rs1     = '0;
    dec_rs2     = '0;
    dec_op      = ALU_ADD;
    dec_illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE ||
            (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          dec_rs1 = byp_rs1;
          dec_rs2 = byp_rs2;
          dec_op  = f3_to_alu(funct3, funct7 == F7_ALT);
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        if ((funct3 == 3'b001 && funct7 != F7_BASE) ||
            (funct3 == 3'b101 && funct7 != F7_BASE && funct7 != F7_ALT)) begin
          dec_illegal = 1'b1;
        end else begin
          dec_rs1 = byp_rs1;
          dec_op  = f3_to_alu(funct3, funct3 == 3'b101 && funct7 == F7_ALT);
          if (funct3 == 3'b001 || funct3 == 3'b101) dec_rs2 = XLEN'(instr[24:20]);
          else                                      dec_rs2 = XLEN'($signed(instr[31:20]));
        end
      end
      OPC_LUI: begin
        dec_rs2 = XLEN'($signed({instr[31:12], 12'b0}));
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  logic            out_valid_d, out_valid_q;
  logic [XLEN-1:0] rs1_val_d, rs1_val_q, rs2_val_d, rs2_val_q;
  alu_op_e         alu_op_d, alu_op_q;
  logic [4:0]      rd_d, rd_q;
  logic            rd_we_d, rd_we_q, illegal_d, illegal_q;
  logic            accept;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Output register next state: load on acceptance, drain on out_ready, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    rs1_val_d   = rs1_val_q;
    rs2_val_d   = rs2_val_q;
    alu_op_d    = alu_op_q;
    rd_d        = rd_q;
    rd_we_d     = rd_we_q;
    illegal_d   = illegal_q;
    if (accept) begin
      out_valid_d = 1'b1;
      rs1_val_d   = dec_rs1;
      rs2_val_d   = dec_rs2;
      alu_op_d    = dec_op;
      rd_d        = dec_illegal ? 5'd0 : rd_idx;
      rd_we_d     = !dec_illegal && rd_idx != 5'd0;
      illegal_d   = dec_illegal;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register state; reset discards any held instruction.
  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      rs1_val_q   <= '0;
      rs2_val_q   <= '0;
      alu_op_q    <= ALU_ADD;
      rd_q        <= '0;
      rd_we_q     <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      rs1_val_q   <= rs1_val_d;
      rs2_val_q   <= rs2_val_d;
      alu_op_q    <= alu_op_d;
      rd_q        <= rd_d;
      rd_we_q     <= rd_we_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign rs1_val   = rs1_val_q;
  assign rs2_val   = rs2_val_q;
  assign alu_op    = alu_op_q;
  assign rd        = rd_q;
  assign rd_we     = rd_we_q;
  assign illegal   = illegal_q;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath and register width.
REQ-002 SHALL have parameter NREGS, default 32, meaning architectural register count.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, upstream instruction valid.
REQ-006 SHALL have port in_ready, output, 1, stage can accept an instruction.
REQ-007 SHALL have port instr, input, 32, RV32I instruction word.
REQ-008 SHALL have port wb_en, input, 1, writeback strobe.
REQ-009 SHALL have port wb_rd, input, 5, writeback destination index.
REQ-010 SHALL have port wb_val, input, XLEN, writeback data.
REQ-011 SHALL have port out_valid, output, 1, decoded operands valid to the ALU.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts the output.
REQ-013 SHALL have port rs1_val, output, XLEN, ALU operand A.
REQ-014 SHALL have port rs2_val, output, XLEN, ALU operand B (register or immediate).
REQ-015 SHALL have port alu_op, output, 4, ALU operation code.
REQ-016 SHALL have port rd, output, 5, destination register index.
REQ-017 SHALL have port rd_we, output, 1, result is to be written back.
REQ-018 SHALL have port illegal, output, 1, instruction not supported by this stage.

Function
REQ-019 SHALL encode alu_op as ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
REQ-020 SHALL decode OP (0110011): rs2_val = x[rs2]; funct7 0000000 for all funct3; funct7 0100000 only with funct3 000 (SUB) or 101 (SRA).
REQ-021 SHALL decode OP-IMM (0010011): rs2_val = sign-extended imm[11:0]; SLLI requires funct7 0000000, SRLI/SRAI funct7 0000000/0100000; rs2_val = zero-extended shamt for shifts.
REQ-022 SHALL decode LUI (0110111): rs1_val = 0, rs2_val = {imm[31:12],12'b0}, alu_op ADD.
REQ-023 SHALL, for any other opcode or any disallowed funct7, set illegal=1, rd_we=0, alu_op=ADD, operands 0.
REQ-024 SHALL set rd_we=1 for legal instructions with rd!=0, and 0 when rd==0.
REQ-025 SHALL contain an NREGS x XLEN register file; x0 reads 0 always; writes to x0 are ignored.
REQ-026 SHALL write wb_val to x[wb_rd] on a clock edge when wb_en=1.
REQ-027 SHALL bypass: when wb_en=1 and wb_rd matches rs1/rs2 (nonzero) in the acceptance cycle, the captured operand equals wb_val.
REQ-028 SHALL drive in_ready = !out_valid || out_ready (combinational, single output register).
REQ-029 SHALL accept on in_valid && in_ready, registering all outputs; latency one cycle from acceptance to out_valid.
REQ-030 SHALL clear out_valid when out_ready=1 and no new acceptance occurs in that cycle; accept-and-drain in the same cycle keeps out_valid=1 with the new data.
REQ-031 SHALL hold all outputs stable while out_valid=1 and out_ready=0.
REQ-032 SHALL capture operands at acceptance only; later writebacks do not alter held outputs.

Reset
REQ-033 SHALL, while rst_n=0, force out_valid=0, rs1_val=0, rs2_val=0, alu_op=0, rd=0, rd_we=0, illegal=0, all registers 0.
REQ-034 SHALL discard any held instruction on reset assertion mid-operation; in_ready=1 from the first cycle after release.

Structure
REQ-035 SHALL place the alu_op enum, opcode constants and funct7 constants in shared package riscv_pkg, also used by alu.
REQ-036 SHALL implement the register file as sub-module regfile (two combinational read ports, one synchronous write port).

Verification
REQ-037 SHALL cover: wb x1=4, x2=2; ADD x3,x1,x2 -> rs1_val=4, rs2_val=2, alu_op=0, rd=3, rd_we=1.
REQ-038 SHALL cover: ADDI x5,x0,-1 -> rs2_val=32'hFFFFFFFF, alu_op=0; SRAI x6,x1,4 -> rs2_val=4, alu_op=7.
REQ-039 SHALL cover: wb_en=1, wb_rd=7, wb_val=32'hDEADBEEF in the acceptance cycle of OR x8,x7,x0 -> rs1_val=32'hDEADBEEF, alu_op=8.
REQ-040 SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs unchanged; out_ready=1 -> next instruction appears the following cycle.
REQ-041 SHALL cover: opcode 1100011 or SLLI with funct7 0100000 -> illegal=1, rd_we=0; ADD x0,x1,x2 -> rd_we=0.
REQ-042 SHALL cover: rst_n asserted while out_valid=1 -> out_valid=0 and x1 reads 0 after release.
